fp8_exp2_int: RTL

- Streaming inverse of the FP8 integer-log encoder: accepts an E4M3 FP8 value x that carries an integer exponent, and returns 2^floor(x) as E4M3 FP8.
- E4M3 format: bias 7, 3-bit mantissa; exponent field 0 is subnormal; x_1111_111 is NaN.
- Sits after the log-domain arithmetic to bring results back to the linear domain.
- Two-stage valid/ready pipeline: stage 1 decodes, stage 2 applies floor and encodes.

---
 rtl/fp8_exp2_int.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fp8_exp2_int.sv
// fp8_exp2_int: streaming 2^floor(x) for E4M3 FP8 operands, two-stage valid/ready pipeline.
// Define FP8_EXP2_FLAGS_EN to add the {invalid, overflow, underflow, inexact} out_flags port.
module fp8_exp2_int #(
    parameter bit UNDERFLOW_MIN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
`ifdef FP8_EXP2_FLAGS_EN
    ,
    output logic [3:0] out_flags
`endif
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned EXP_W  = 4;
    localparam int unsigned MAN_W  = 3;
    localparam int unsigned MAG_W  = 5;
    localparam int unsigned INT_W  = 6;
`ifdef FP8_EXP2_FLAGS_EN
    localparam int unsigned FLAG_W = 4;
`endif

    localparam logic [DATA_W-1:0] NAN_OUT = 8'h7F;
    localparam logic [DATA_W-1:0] MAX_OUT = 8'h7E;

    // Decoded operand carried from stage 1 to stage 2
    typedef struct packed {
        logic                    nan;
        logic                    sign;
        logic                    frac;
        logic signed [INT_W-1:0] trunc;
    } dec_t;

    logic              s1_valid;
    logic              s2_valid;
    logic              s2_load;
    dec_t              s1_q;
    dec_t              dec_c;
    logic [EXP_W-1:0]  exp_f;
    logic [MAN_W-1:0]  man_f;
    logic [MAG_W-1:0]  mag;
    logic [1:0]        sh;
    logic signed [INT_W-1:0] n_c;
    logic [1:0]        sub_sh;
    logic [DATA_W-1:0] enc_data_c;
`ifdef FP8_EXP2_FLAGS_EN
    logic [FLAG_W-1:0] enc_flags_c;
`endif

    // Pipeline control: stage 2 frees when empty or drained; stage 1 rides behind it
    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !rst && (!s1_valid || s2_load);
    assign out_valid = s2_valid;

    // Stage 1: integer part truncated toward zero, clamped to [-16, 15]
    always_comb begin
        exp_f = in_data[6:3];
        man_f = in_data[2:0];
        mag   = '0;
        sh    = '0;
        dec_c = '0;

        dec_c.sign = in_data[7];
        dec_c.nan  = (exp_f == 4'hF) && (man_f == 3'h7);

        if (exp_f == 4'd0) begin
            dec_c.frac = |man_f;
        end else if (exp_f < 4'd7) begin
            dec_c.frac = 1'b1;
        end else if (exp_f < 4'd11) begin
            sh         = 2'(exp_f - 4'd7);
            mag        = {1'b0, {1'b1, man_f} >> (2'd3 - sh)};
            dec_c.frac = |(man_f & (3'b111 >> sh));
        end else begin
            mag = in_data[7] ? 5'd16 : 5'd15;
        end

        dec_c.trunc = in_data[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

    // Stage 2: floor (negative fractions step down by one) then encode 2^n
    always_comb begin
        n_c        = s1_q.trunc - $signed({5'd0, s1_q.sign & s1_q.frac});
        sub_sh     = '0;
        enc_data_c = '0;
`ifdef FP8_EXP2_FLAGS_EN
        enc_flags_c = '0;
        enc_flags_c[0] = s1_q.frac;
`endif

        if (s1_q.nan) begin
            enc_data_c = NAN_OUT;
`ifdef FP8_EXP2_FLAGS_EN
            enc_flags_c = 4'b1000;
`endif
        end else if (n_c > 6'sd8) begin
            enc_data_c = MAX_OUT;
`ifdef FP8_EXP2_FLAGS_EN
            enc_flags_c[2] = 1'b1;
`endif
        end else if (n_c < -6'sd9) begin
            enc_data_c = {7'd0, UNDERFLOW_MIN};
`ifdef FP8_EXP2_FLAGS_EN
            enc_flags_c[1] = 1'b1;
`endif
        end else if (n_c < -6'sd6) begin
            sub_sh     = 2'(n_c + 6'sd9);
            enc_data_c = {5'd0, 3'b001 << sub_sh};
        end else begin
            enc_data_c = {1'b0, 4'(n_c + 6'sd7), 3'b000};
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            out_data <= '0;
`ifdef FP8_EXP2_FLAGS_EN
            out_flags <= '0;
`endif
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= enc_data_c;
`ifdef FP8_EXP2_FLAGS_EN
                    out_flags <= enc_flags_c;
`endif
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= dec_c;
                end
            end
        end
    end

endmodule
